// File: rtl/spi_slave_core.sv
// spi_slave_core: full-duplex SPI slave oversampled on clk.
// All SPI pins are synchronised into the clk domain; edges are detected
// from the synchronised copies, so every pin event is acted on 3 clk
// cycles after it happens. Supports all four SPI modes, either bit order
// and multi-word bursts within one chip-select window.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | cs_n high, miso tri-stated, bit counter and shifters clear
// ST_ACTIVE | cs_n low, shifting words; miso driven from the tx shifter
module spi_slave_core #(
  parameter int                    DATA_WIDTH = 8,
  parameter bit                    CPOL       = 1'b0,
  parameter bit                    CPHA       = 1'b0,
  parameter bit                    MSB_FIRST  = 1'b1,
  parameter logic [DATA_WIDTH-1:0] IDLE_FILL  = '1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  tx_underrun,
  output logic                  frame_err
);

  localparam int              CW       = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0]   LAST_BIT = CW'(DATA_WIDTH - 1);
  localparam logic [0:0]      ST_IDLE   = 1'b0;
  localparam logic [0:0]      ST_ACTIVE = 1'b1;

  logic                  sclk_s1, sclk_s2, sclk_s3;
  logic                  cs_s1, cs_s2, cs_s3;
  logic                  mosi_s1, mosi_s2;

  logic [0:0]            state;
  logic [CW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] rx_sh;
  logic [DATA_WIDTH-1:0] tx_sh;
  logic                  buf_full;
  logic [DATA_WIDTH-1:0] buf_data;

  logic                  lead_edge, trail_edge;
  logic                  sample_edge, shift_edge;
  logic                  cs_fall, cs_rise;
  logic                  frame_start, frame_stop;
  logic                  do_sample, do_shift, word_done;
  logic                  load, tx_hs;
  logic [DATA_WIDTH-1:0] rx_next;
  logic [DATA_WIDTH-1:0] tx_next;

  // Two-flop synchronisers on all pins plus a third stage on sclk/cs_n for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_s1 <= CPOL;
      sclk_s2 <= CPOL;
      sclk_s3 <= CPOL;
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      cs_s3   <= 1'b1;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      sclk_s1 <= sclk;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      cs_s1   <= cs_n;
      cs_s2   <= cs_s1;
      cs_s3   <= cs_s2;
      mosi_s1 <= mosi;
      mosi_s2 <= mosi_s1;
    end
  end

  assign lead_edge   = (sclk_s3 == CPOL) && (sclk_s2 != CPOL);
  assign trail_edge  = (sclk_s3 != CPOL) && (sclk_s2 == CPOL);
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge  : trail_edge;
  assign cs_fall     = cs_s3 & ~cs_s2;
  assign cs_rise     = ~cs_s3 & cs_s2;

  // Frame start wins over a coincident sclk edge; frame stop wins over everything.
  assign frame_start = (state == ST_IDLE) && cs_fall;
  assign frame_stop  = (state == ST_ACTIVE) && cs_rise;
  assign do_sample   = (state == ST_ACTIVE) && !cs_rise && sample_edge;
  assign word_done   = do_sample && (bit_cnt == LAST_BIT);

  // The first shift edge of each word (counter still 0) must not advance the
  // shifter: the freshly loaded first bit is already on miso.
  assign do_shift    = (state == ST_ACTIVE) && !cs_rise && shift_edge && (bit_cnt != '0);

  assign load        = frame_start | word_done;
  assign tx_hs       = tx_valid && !buf_full;
  assign tx_ready    = !buf_full;

  assign rx_next = MSB_FIRST ? {rx_sh[DATA_WIDTH-2:0], mosi_s2}
                             : {mosi_s2, rx_sh[DATA_WIDTH-1:1]};
  assign tx_next = MSB_FIRST ? {tx_sh[DATA_WIDTH-2:0], 1'b0}
                             : {1'b0, tx_sh[DATA_WIDTH-1:1]};

  // Frame state: enter on synced cs_n falling, leave on synced cs_n rising.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else if (frame_start) begin
      state <= ST_ACTIVE;
    end else if (frame_stop) begin
      state <= ST_IDLE;
    end
  end

  // Bit counter: counts sample edges within a word, wraps at the word boundary.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt <= '0;
    end else if (frame_start || frame_stop) begin
      bit_cnt <= '0;
    end else if (do_sample) begin
      bit_cnt <= word_done ? '0 : bit_cnt + CW'(1);
    end
  end

  // Receive shifter and completed-word register; partial words are dropped on stop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_sh   <= '0;
      rx_data <= '0;
    end else if (frame_start || frame_stop) begin
      rx_sh <= '0;
    end else if (do_sample) begin
      rx_sh <= word_done ? '0 : rx_next;
      if (word_done) begin
        rx_data <= rx_next;
      end
    end
  end

  // One-deep tx buffer; a load in the same cycle as a handshake sees the old contents.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_full <= 1'b0;
      buf_data <= '0;
    end else if (tx_hs) begin
      buf_full <= 1'b1;
      buf_data <= tx_data;
    end else if (load) begin
      buf_full <= 1'b0;
    end
  end

  // Transmit shifter: loaded at frame start and each word boundary, advanced on shift edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_sh <= '0;
    end else if (load) begin
      tx_sh <= buf_full ? buf_data : IDLE_FILL;
    end else if (frame_stop) begin
      tx_sh <= '0;
    end else if (do_shift) begin
      tx_sh <= tx_next;
    end
  end

  // Single-cycle status pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      rx_valid    <= word_done;
      tx_underrun <= load && !buf_full;
      frame_err   <= frame_stop && (bit_cnt != '0);
    end
  end

  assign miso_oe = (state == ST_ACTIVE);
  assign miso    = miso_oe & (MSB_FIRST ? tx_sh[DATA_WIDTH-1] : tx_sh[0]);

endmodule

// File: tb/tb_spi_slave_core.sv
// Bench for spi_slave_core: two instances (mode 0 / W=8 / MSB first and
// mode 3 / W=16 / LSB first) share sclk and mosi, each has its own cs_n.
// A behavioural SPI master drives frames; a table of frame vectors is
// applied in a loop, followed by burst and reset-mid-frame sequences.
module tb_spi_slave_core;

  localparam int H = 8;  // SCLK half period in clk cycles

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic sclk, mosi, cs0_n, cs1_n;

  logic        miso0, oe0, rdy0, rv0, ur0, fe0, txv0;
  logic [7:0]  txd0, rxd0;
  logic        miso1, oe1, rdy1, rv1, ur1, fe1, txv1;
  logic [15:0] txd1, rxd1;

  spi_slave_core #(.DATA_WIDTH(8), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1)) u_dut0 (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs0_n), .mosi(mosi),
    .miso(miso0), .miso_oe(oe0), .tx_data(txd0), .tx_valid(txv0), .tx_ready(rdy0),
    .rx_data(rxd0), .rx_valid(rv0), .tx_underrun(ur0), .frame_err(fe0)
  );

  spi_slave_core #(.DATA_WIDTH(16), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0)) u_dut1 (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs1_n), .mosi(mosi),
    .miso(miso1), .miso_oe(oe1), .tx_data(txd1), .tx_valid(txv1), .tx_ready(rdy1),
    .rx_data(rxd1), .rx_valid(rv1), .tx_underrun(ur1), .frame_err(fe1)
  );

  typedef struct {
    int          sel;
    bit          pre;
    logic [31:0] tx;
    logic [31:0] mw;
    int          nbits;
    logic [31:0] exp_rx;
    logic [31:0] exp_cap;
    int          exp_rv;
    int          exp_urs;
    int          exp_urb;
    int          exp_fe;
  } vec_t;

  int n_chk = 0;
  int n_err = 0;

  // master state
  int          cw;
  bit          ccpol, ccpha, cmsb;
  int          csel;
  logic [31:0] m_tx [0:1];
  logic [31:0] m_cap [0:1];
  logic        oe_after3;

  // pulse monitors
  int          rv_cnt [0:1] = '{0, 0};
  int          urs_cnt [0:1] = '{0, 0};
  int          fe_cnt [0:1] = '{0, 0};
  logic [31:0] rx_log [0:1][0:7];
  logic        ur_log [0:1][0:7];

  // Pulse monitor sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rv0) begin
      if (rv_cnt[0] < 8) begin
        rx_log[0][rv_cnt[0]] = {24'b0, rxd0};
        ur_log[0][rv_cnt[0]] = ur0;
      end
      rv_cnt[0]++;
    end else if (ur0) urs_cnt[0]++;
    if (fe0) fe_cnt[0]++;
    if (rv1) begin
      if (rv_cnt[1] < 8) begin
        rx_log[1][rv_cnt[1]] = {16'b0, rxd1};
        ur_log[1][rv_cnt[1]] = ur1;
      end
      rv_cnt[1]++;
    end else if (ur1) urs_cnt[1]++;
    if (fe1) fe_cnt[1]++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic cur_miso(input int s);
    return (s == 0) ? miso0 : miso1;
  endfunction
  function automatic logic cur_oe(input int s);
    return (s == 0) ? oe0 : oe1;
  endfunction
  function automatic logic cur_rdy(input int s);
    return (s == 0) ? rdy0 : rdy1;
  endfunction
  function automatic logic [31:0] cur_rx(input int s);
    return (s == 0) ? {24'b0, rxd0} : {16'b0, rxd1};
  endfunction

  task automatic push_tx(input int s, input logic [31:0] d);
    logic ok;
    ok = 1'b0;
    @(negedge clk);
    if (s == 0) begin txd0 = d[7:0]; txv0 = 1'b1; end
    else        begin txd1 = d[15:0]; txv1 = 1'b1; end
    for (int k = 0; k < 50 && !ok; k++) begin
      if (cur_rdy(s)) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    txv0 = 1'b0;
    txv1 = 1'b0;
    chk("tx_handshake_done", {31'b0, ok}, 32'd1);
  endtask

  task automatic frame_begin(input int s);
    csel  = s;
    cw    = (s == 0) ? 8 : 16;
    ccpol = (s != 0);
    ccpha = (s != 0);
    cmsb  = (s == 0);
    m_cap[0] = '0;
    m_cap[1] = '0;
    sclk = ccpol;
    repeat (H) @(negedge clk);
    if (s == 0) cs0_n = 1'b0; else cs1_n = 1'b0;
    repeat (H) @(negedge clk);
  endtask

  task automatic xfer_bit(input int i);
    int          w, p, bp;
    logic [31:0] word;
    w  = i / cw;
    p  = i % cw;
    bp = cmsb ? (cw - 1 - p) : p;
    word = m_tx[w];
    if (!ccpha) begin
      mosi = word[bp];
      repeat (H) @(negedge clk);
      sclk = ~ccpol;
      m_cap[w][bp] = cur_miso(csel);
      repeat (H) @(negedge clk);
      sclk = ccpol;
    end else begin
      sclk = ~ccpol;
      mosi = word[bp];
      repeat (H) @(negedge clk);
      sclk = ccpol;
      m_cap[w][bp] = cur_miso(csel);
      repeat (H) @(negedge clk);
    end
  endtask

  task automatic frame_end();
    repeat (H) @(negedge clk);
    if (csel == 0) cs0_n = 1'b1; else cs1_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    oe_after3 = cur_oe(csel);
    repeat (H) @(negedge clk);
  endtask

  task automatic run_frame(input int s, input int nbits);
    frame_begin(s);
    for (int i = 0; i < nbits; i++) xfer_bit(i);
    frame_end();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs [0:4];
    int   rvb, ursb, feb, ub, s;

    vecs[0] = '{0, 1'b1, 32'h3C,   32'hA5,   8,  32'hA5,   32'h3C,   1, 0, 1, 0};
    vecs[1] = '{0, 1'b0, 32'h00,   32'h5A,   8,  32'h5A,   32'hFF,   1, 1, 1, 0};
    vecs[2] = '{1, 1'b1, 32'h1234, 32'hBEEF, 16, 32'hBEEF, 32'h1234, 1, 0, 1, 0};
    vecs[3] = '{0, 1'b1, 32'hE7,   32'h33,   5,  32'h5A,   32'hE0,   0, 0, 0, 1};
    vecs[4] = '{0, 1'b1, 32'h81,   32'h7E,   8,  32'h7E,   32'h81,   1, 0, 1, 0};

    rst = 1'b0;
    sclk = 1'b0; mosi = 1'b0; cs0_n = 1'b1; cs1_n = 1'b1;
    txv0 = 1'b0; txv1 = 1'b0; txd0 = '0; txd1 = '0;
    m_tx[0] = '0; m_tx[1] = '0;
    repeat (3) @(negedge clk);

    for (int k = 0; k < 2; k++) begin
      chk("reset_miso",      {31'b0, cur_miso(k)}, 32'd0);
      chk("reset_miso_oe",   {31'b0, cur_oe(k)},   32'd0);
      chk("reset_tx_ready",  {31'b0, cur_rdy(k)},  32'd1);
      chk("reset_rx_data",   cur_rx(k),            32'd0);
    end
    chk("reset_pulses0", {29'b0, rv0, ur0, fe0}, 32'd0);
    chk("reset_pulses1", {29'b0, rv1, ur1, fe1}, 32'd0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      s = vecs[v].sel;
      if (vecs[v].pre) begin
        push_tx(s, vecs[v].tx);
        @(negedge clk);
        chk($sformatf("v%0d_tx_ready_full", v), {31'b0, cur_rdy(s)}, 32'd0);
      end
      rvb  = rv_cnt[s];
      ursb = urs_cnt[s];
      feb  = fe_cnt[s];
      m_tx[0] = vecs[v].mw;
      m_tx[1] = '0;
      run_frame(s, vecs[v].nbits);
      ub = 0;
      for (int k = rvb; k < rv_cnt[s] && k < 8; k++) ub += int'(ur_log[s][k]);
      chk($sformatf("v%0d_rx_data", v),      cur_rx(s),               vecs[v].exp_rx);
      chk($sformatf("v%0d_master_cap", v),   m_cap[0],                vecs[v].exp_cap);
      chk($sformatf("v%0d_rx_valid_cnt", v), rv_cnt[s] - rvb,         vecs[v].exp_rv);
      chk($sformatf("v%0d_underrun_start", v), urs_cnt[s] - ursb,     vecs[v].exp_urs);
      chk($sformatf("v%0d_underrun_bound", v), ub,                    vecs[v].exp_urb);
      chk($sformatf("v%0d_frame_err_cnt", v), fe_cnt[s] - feb,        vecs[v].exp_fe);
      chk($sformatf("v%0d_oe_after3", v),    {31'b0, oe_after3},      32'd0);
      chk($sformatf("v%0d_idle_miso", v),    {31'b0, cur_miso(s)},    32'd0);
      chk($sformatf("v%0d_tx_ready_after", v), {31'b0, cur_rdy(s)},   32'd1);
    end

    // Burst: two words in one cs_n window, second tx word handshaken mid-word.
    push_tx(0, 32'h11);
    rvb  = rv_cnt[0];
    ursb = urs_cnt[0];
    feb  = fe_cnt[0];
    m_tx[0] = 32'hC3;
    m_tx[1] = 32'h5A;
    fork
      run_frame(0, 16);
      begin
        repeat (40) @(negedge clk);
        push_tx(0, 32'h22);
      end
    join
    chk("burst_rx_valid_cnt", rv_cnt[0] - rvb, 32'd2);
    chk("burst_rx_word0",     rx_log[0][rvb],     32'hC3);
    chk("burst_rx_word1",     rx_log[0][rvb + 1], 32'h5A);
    chk("burst_cap_word0",    m_cap[0],           32'h11);
    chk("burst_cap_word1",    m_cap[1],           32'h22);
    chk("burst_underrun_start", urs_cnt[0] - ursb, 32'd0);
    chk("burst_underrun_word0", {31'b0, ur_log[0][rvb]}, 32'd0);
    chk("burst_frame_err",    fe_cnt[0] - feb,    32'd0);

    // Reset mid-frame after 3 bits, then a clean frame.
    push_tx(0, 32'h99);
    feb = fe_cnt[0];
    m_tx[0] = 32'hF0;
    m_tx[1] = '0;
    frame_begin(0);
    for (int i = 0; i < 3; i++) xfer_bit(i);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstmid_miso",     {31'b0, miso0}, 32'd0);
    chk("rstmid_miso_oe",  {31'b0, oe0},   32'd0);
    chk("rstmid_tx_ready", {31'b0, rdy0},  32'd1);
    chk("rstmid_rx_data",  {24'b0, rxd0},  32'd0);
    chk("rstmid_pulses",   {29'b0, rv0, ur0, fe0}, 32'd0);
    repeat (2) @(negedge clk);
    cs0_n = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("rstmid_no_frame_err", fe_cnt[0] - feb, 32'd0);

    push_tx(0, 32'h5C);
    rvb = rv_cnt[0];
    m_tx[0] = 32'h96;
    run_frame(0, 8);
    chk("post_rst_rx_data",   {24'b0, rxd0}, 32'h96);
    chk("post_rst_cap",       m_cap[0],      32'h5C);
    chk("post_rst_rv_cnt",    rv_cnt[0] - rvb, 32'd1);
    chk("post_rst_frame_err", fe_cnt[0] - feb, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
